// File: rtl/spsram_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spsram_fifo_ctrl_pkg
// Shared definitions for the single-port-SRAM FIFO controller:
//   - default address width and the matching FIFO depth
//   - the memory command encodings, each packed as {cen, wen, oen}
//   - a helper that turns an address width into a depth
// -----------------------------------------------------------------------------
package spsram_fifo_ctrl_pkg;

    localparam int BW_ADDR_DEFAULT = 5;
    localparam int FIFO_DEPTH      = 2 ** BW_ADDR_DEFAULT;

    // One SRAM access per cycle: nothing, a write, or a read.
    typedef enum logic [2:0] {
        MEM_IDLE = 3'b000,
        MEM_WR   = 3'b110,
        MEM_RD   = 3'b101
    } mem_cmd_e;

    function automatic int fifo_depth(input int bw_addr);
        return 2 ** bw_addr;
    endfunction

endpackage

// File: rtl/spsram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// spsram_fifo_ctrl
// Synchronous FIFO controller driving the single port of an spsram macro.
// A push stream and a pop stream share the port: each cycle it does at most
// one access, and a read always wins over a write. The head entry lives in a
// one-entry output register, so the FIFO holds up to DEPTH+1 entries.
//
// Ports
//   i_clk, i_rst      clock (rising edge) and synchronous active-high reset
//   i_in_valid        push request
//   i_in_data         push data
//   o_in_ready        push accepted when high together with i_in_valid
//   o_out_valid       head entry present on o_out_data
//   o_out_data        head entry (registered)
//   i_out_ready       consumer takes the head when high with o_out_valid
//   o_count           entries held (SRAM + read in flight + output register)
//   o_mem_data        to spsram i_data
//   o_mem_addr        to spsram i_addr
//   o_mem_wen         to spsram i_wen
//   o_mem_cen         to spsram i_cen
//   o_mem_oen         to spsram i_oen
//   i_mem_data        from spsram o_data (valid the cycle after a read edge)
// -----------------------------------------------------------------------------
module spsram_fifo_ctrl
    import spsram_fifo_ctrl_pkg::*;
#(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = BW_ADDR_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in_valid,
    input  logic [BW_DATA-1:0] i_in_data,
    output logic               o_in_ready,
    output logic               o_out_valid,
    output logic [BW_DATA-1:0] o_out_data,
    input  logic               i_out_ready,
    output logic [BW_ADDR:0]   o_count,
    output logic [BW_DATA-1:0] o_mem_data,
    output logic [BW_ADDR-1:0] o_mem_addr,
    output logic               o_mem_wen,
    output logic               o_mem_cen,
    output logic               o_mem_oen,
    input  logic [BW_DATA-1:0] i_mem_data
);

    localparam int                CNT_W    = BW_ADDR + 1;
    localparam int                DEPTH    = fifo_depth(BW_ADDR);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    logic [BW_ADDR-1:0] r_wr_ptr;
    logic [BW_ADDR-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_mem_cnt;
    logic               r_rd_inflight;
    logic               r_out_valid;
    logic [BW_DATA-1:0] r_out_data;

    logic               w_rd_go;
    logic               w_in_ready;
    logic               w_push;
    mem_cmd_e           w_cmd;
    logic [BW_ADDR-1:0] w_mem_addr;
    logic [BW_DATA-1:0] w_mem_data;

    // Fetch the next SRAM entry whenever the output register is free (or is
    // being emptied this cycle) and no fetch is already on its way. Holding
    // off while a read is in flight keeps rd_inflight and out_valid exclusive.
    assign w_rd_go = !i_rst
                  && (r_mem_cnt != '0)
                  && !r_rd_inflight
                  && (!r_out_valid || i_out_ready);

    // Full is judged on SRAM occupancy alone; popping the head does not free
    // an SRAM slot until the following read completes.
    assign w_in_ready = !i_rst && (r_mem_cnt != CNT_FULL) && !w_rd_go;
    assign w_push     = i_in_valid && w_in_ready;

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_cmd      = MEM_IDLE;
        w_mem_addr = '0;
        w_mem_data = '0;
        if (w_rd_go) begin
            w_cmd      = MEM_RD;
            w_mem_addr = r_rd_ptr;
        end else if (w_push) begin
            w_cmd      = MEM_WR;
            w_mem_addr = r_wr_ptr;
            w_mem_data = i_in_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Only the control state is cleared; the SRAM keeps its contents
            // and any read already issued is simply not captured.
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_mem_cnt     <= '0;
            r_rd_inflight <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + BW_ADDR'(1);
            end
            if (w_rd_go) begin
                r_rd_ptr <= r_rd_ptr + BW_ADDR'(1);
            end

            // Push and read never coincide, so at most one adjusts the count.
            if (w_push) begin
                r_mem_cnt <= r_mem_cnt + CNT_W'(1);
            end else if (w_rd_go) begin
                r_mem_cnt <= r_mem_cnt - CNT_W'(1);
            end

            r_rd_inflight <= w_rd_go;

            // Read data lands one edge after the read was issued.
            if (r_rd_inflight) begin
                r_out_data  <= i_mem_data;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign {o_mem_cen, o_mem_wen, o_mem_oen} = w_cmd;
    assign o_mem_addr  = w_mem_addr;
    assign o_mem_data  = w_mem_data;
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_count     = r_mem_cnt
                       + {{BW_ADDR{1'b0}}, r_rd_inflight}
                       + {{BW_ADDR{1'b0}}, r_out_valid};

endmodule

// File: tb/tb_spsram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spsram_fifo_ctrl
// Bench for spsram_fifo_ctrl with a behavioural single-port SRAM attached.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A monitor records every accepted push in a queue and compares
// every pop against the queue head.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spsram_fifo_ctrl;

    localparam int BW_DATA = 32;
    localparam int BW_ADDR = 5;
    localparam int DEPTH   = 2 ** BW_ADDR;

    logic               i_clk;
    logic               i_rst;
    logic               i_in_valid;
    logic [BW_DATA-1:0] i_in_data;
    logic               o_in_ready;
    logic               o_out_valid;
    logic [BW_DATA-1:0] o_out_data;
    logic               i_out_ready;
    logic [BW_ADDR:0]   o_count;
    logic [BW_DATA-1:0] o_mem_data;
    logic [BW_ADDR-1:0] o_mem_addr;
    logic               o_mem_wen;
    logic               o_mem_cen;
    logic               o_mem_oen;
    logic [BW_DATA-1:0] i_mem_data;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    bit sb_en  = 1'b0;
    logic [BW_DATA-1:0] sb_q[$];

    spsram_fifo_ctrl #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .i_out_ready (i_out_ready),
        .o_count     (o_count),
        .o_mem_data  (o_mem_data),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wen   (o_mem_wen),
        .o_mem_cen   (o_mem_cen),
        .o_mem_oen   (o_mem_oen),
        .i_mem_data  (i_mem_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural single-port SRAM: write or registered read on the edge.
    logic [BW_DATA-1:0] sram [DEPTH];
    always @(posedge i_clk) begin
        if (o_mem_cen && o_mem_wen) begin
            sram[o_mem_addr] <= o_mem_data;
        end
        if (o_mem_cen && !o_mem_wen && o_mem_oen) begin
            i_mem_data <= sram[o_mem_addr];
        end
    end

    // Scoreboard monitor.
    always @(negedge i_clk) begin
        if (sb_en && !i_rst) begin
            if (i_in_valid && o_in_ready) begin
                sb_q.push_back(i_in_data);
            end
            if (o_out_valid && i_out_ready) begin
                logic [BW_DATA-1:0] exp_v;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_underflow: got %h, expected no pop", o_out_data);
                end else begin
                    exp_v = sb_q.pop_front();
                    pops++;
                    if (o_out_data !== exp_v) begin
                        errors++;
                        $display("FAIL pop_data: got %h, expected %h", o_out_data, exp_v);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Offer one word and hold it until the controller accepts it.
    task automatic push_word(input logic [BW_DATA-1:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        i_in_valid = 1'b1;
        i_in_data  = d;
        while (!acc && n < 20) begin
            @(negedge i_clk);
            acc = o_in_ready;
            tick();
            n++;
        end
        i_in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout: word %h not accepted in 20 cycles", d);
        end
    endtask

    // Hold i_out_ready high until the FIFO is empty.
    task automatic drain(input string name);
        int n;
        n = 0;
        i_out_ready = 1'b1;
        @(negedge i_clk);
        while (o_count != 0 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_count !== 0) begin
            errors++;
            $display("FAIL %s_drain: count %0d, expected 0", name, o_count);
        end
        tick();
    endtask

    task automatic test_reset();
        i_rst       = 1'b1;
        i_in_valid  = 1'b1;
        i_in_data   = 32'hFFFF_FFFF;
        i_out_ready = 1'b0;
        repeat (2) tick();
        @(negedge i_clk);
        checks++;
        if (o_out_valid !== 1'b0 || o_out_data !== '0 || o_count !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h count=%0d, expected 0/0/0",
                     o_out_valid, o_out_data, o_count);
        end
        checks++;
        if (o_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 0", o_in_ready);
        end
        checks++;
        if ({o_mem_cen, o_mem_wen, o_mem_oen} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b, expected 000",
                     {o_mem_cen, o_mem_wen, o_mem_oen});
        end
        tick();
        i_in_valid = 1'b0;
        i_rst      = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %b, expected 1", o_in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        int p0;
        p0 = pops;
        i_out_ready = 1'b1;
        push_word(32'hA5);
        // Now just past the accepting edge N.
        checks++;
        if (o_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_n0: valid %b, expected 0", o_out_valid);
        end
        tick();
        checks++;
        if (o_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_n1: valid %b, expected 0", o_out_valid);
        end
        tick();
        checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 32'hA5) begin
            errors++;
            $display("FAIL latency_n2: valid=%b data=%h, expected 1/a5", o_out_valid, o_out_data);
        end
        push_word(32'h5A);
        push_word(32'h33);
        drain("basic");
        checks++;
        if (pops - p0 !== 3) begin
            errors++;
            $display("FAIL basic_pops: got %0d, expected 3", pops - p0);
        end
    endtask

    task automatic test_full();
        int accepted;
        int p0;
        bit acc;
        logic [BW_DATA-1:0] v;
        accepted    = 0;
        v           = '0;
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        i_in_data   = v;
        for (int c = 0; c < 80; c++) begin
            @(negedge i_clk);
            acc = i_in_valid && o_in_ready;
            tick();
            if (acc) begin
                accepted++;
                v = v + 1;
                if (v > 40) i_in_valid = 1'b0;
                else        i_in_data  = v;
            end
        end
        i_in_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (accepted !== DEPTH + 1) begin
            errors++;
            $display("FAIL full_accepted: got %0d, expected %0d", accepted, DEPTH + 1);
        end
        checks++;
        if (o_count !== 6'(DEPTH + 1)) begin
            errors++;
            $display("FAIL full_count: got %0d, expected %0d", o_count, DEPTH + 1);
        end
        checks++;
        if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_data !== '0) begin
            errors++;
            $display("FAIL full_state: ready=%b valid=%b data=%h, expected 0/1/0",
                     o_in_ready, o_out_valid, o_out_data);
        end
        // Popping the head while full must still refuse a push.
        tick();
        i_in_valid  = 1'b1;
        i_in_data   = 32'hDEAD_0000;
        i_out_ready = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_ready: got %b, expected 0", o_in_ready);
        end
        tick();
        i_in_valid = 1'b0;
        p0 = pops;
        drain("full");
        checks++;
        if (pops - p0 + 1 !== DEPTH + 1 || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL full_drain_pops: got %0d left %0d, expected %0d left 0",
                     pops - p0 + 1, sb_q.size(), DEPTH + 1);
        end
    endtask

    task automatic test_wrap();
        int in_cnt;
        int p0;
        int n;
        bit acc;
        in_cnt = 0;
        n      = 0;
        p0     = pops;
        while ((in_cnt < 80 || o_count != 0) && n < 3000) begin
            i_in_valid  = (in_cnt < 80) && ($urandom_range(0, 3) != 0);
            i_in_data   = 32'h100 + in_cnt;
            i_out_ready = ($urandom_range(0, 2) != 0);
            @(negedge i_clk);
            acc = i_in_valid && o_in_ready;
            tick();
            if (acc) in_cnt++;
            n++;
        end
        i_in_valid = 1'b0;
        checks++;
        if (pops - p0 !== 80 || sb_q.size() !== 0 || in_cnt !== 80) begin
            errors++;
            $display("FAIL wrap_totals: pushed %0d popped %0d left %0d, expected 80/80/0",
                     in_cnt, pops - p0, sb_q.size());
        end
    endtask

    task automatic test_priority();
        int rd_cycles;
        int bad;
        bit acc;
        logic [BW_DATA-1:0] v;
        rd_cycles   = 0;
        bad         = 0;
        i_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(32'h200 + i);
        v           = 32'h300;
        i_in_valid  = 1'b1;
        i_in_data   = v;
        i_out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            acc = o_in_ready;
            if (o_mem_cen && !o_mem_wen) begin
                rd_cycles++;
                if (o_in_ready !== 1'b0 || o_mem_oen !== 1'b1) begin
                    bad++;
                    $display("FAIL prio_read_cycle: ready=%b oen=%b, expected 0/1",
                             o_in_ready, o_mem_oen);
                end
            end else if (o_in_ready && {o_mem_cen, o_mem_wen, o_mem_oen} !== 3'b110) begin
                bad++;
                $display("FAIL prio_write_cycle: strobes %b, expected 110",
                         {o_mem_cen, o_mem_wen, o_mem_oen});
            end
            tick();
            if (acc) begin
                v         = v + 1;
                i_in_data = v;
            end
        end
        i_in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL prio_collisions: got %0d bad cycles, expected 0", bad);
        end
        checks++;
        if (rd_cycles < 10) begin
            errors++;
            $display("FAIL prio_reads: got %0d read cycles, expected at least 10", rd_cycles);
        end
        drain("prio");
    endtask

    task automatic test_midop_reset();
        int bad;
        bad         = 0;
        i_out_ready = 1'b0;
        push_word(32'hCAFE_F00D);
        @(negedge i_clk);
        checks++;
        if ({o_mem_cen, o_mem_wen, o_mem_oen} !== 3'b101) begin
            errors++;
            $display("FAIL midrst_read_issue: strobes %b, expected 101",
                     {o_mem_cen, o_mem_wen, o_mem_oen});
        end
        tick();
        checks++;
        if (o_count !== 6'd1 || o_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_inflight: count=%0d valid=%b, expected 1/0", o_count, o_out_valid);
        end
        i_rst = 1'b1;
        tick();
        sb_q.delete();
        i_rst = 1'b0;
        checks++;
        if (o_out_valid !== 1'b0 || o_count !== '0 || o_out_data !== '0) begin
            errors++;
            $display("FAIL midrst_state: valid=%b count=%0d data=%h, expected 0/0/0",
                     o_out_valid, o_count, o_out_data);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            if (o_out_valid !== 1'b0 || o_out_data !== '0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midrst_leak: %0d cycles showed data %h, expected none", bad, o_out_data);
        end
    endtask

    initial begin
        i_rst       = 1'b1;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_out_ready = 1'b0;
        #1;
        test_reset();
        sb_en = 1'b1;
        test_basic();
        test_full();
        test_wrap();
        test_priority();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spsram_fifo_ctrl.md
Name: spsram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of spsram and drives its single memory port.
- Converts a valid/ready push stream and a valid/ready pop stream into one SRAM access per cycle, either a write or a read.
- Holds the head entry in a one-entry output register.
- Used wherever the design needs a stream buffer backed by the single-port SRAM macro.

Parameters:
- BW_DATA, 32, data width; matches spsram BW_DATA.
- BW_ADDR, 5, SRAM address width; SRAM depth DEPTH = 2**BW_ADDR.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_in_valid  in  1  push request.
- i_in_data  in  BW_DATA  push data.
- o_in_ready  out  1  push accepted this cycle when high together with i_in_valid.
- o_out_valid  out  1  head entry present on o_out_data.
- o_out_data  out  BW_DATA  head entry (registered).
- i_out_ready  in  1  consumer takes the head when high together with o_out_valid.
- o_count  out  BW_ADDR+1  total entries held (SRAM + in-flight + output register).
- o_mem_data  out  BW_DATA  to spsram i_data.
- o_mem_addr  out  BW_ADDR  to spsram i_addr.
- o_mem_wen  out  1  to spsram i_wen.
- o_mem_cen  out  1  to spsram i_cen.
- o_mem_oen  out  1  to spsram i_oen.
- i_mem_data  in  BW_DATA  from spsram o_data.

Behaviour:
- SRAM contract:
  - Write at the rising edge when cen=1, wen=1.
  - Read issued at the rising edge when cen=1, wen=0, oen=1; read data is valid on i_mem_data after that edge, so it is captured one edge later.
- Internal state:
  - wr_ptr, rd_ptr: BW_ADDR bits; wrap naturally modulo DEPTH.
  - mem_cnt: BW_ADDR+1 bits; entries resident in SRAM.
  - rd_inflight: 1 bit.
  - out_valid: 1 bit.
- Reset (i_rst=1 at an edge):
  - wr_ptr=0, rd_ptr=0, mem_cnt=0, rd_inflight=0, out_valid=0, o_out_data=0.
  - SRAM contents are not cleared.
  - An in-flight read is discarded.
  - While i_rst=1, the memory strobes are held at 0 and o_in_ready=0.
- Read issue (combinational):
  - rd_go = (mem_cnt!=0) && !rd_inflight && (!out_valid || i_out_ready).
  - Read has priority over write.
- Push acceptance (combinational):
  - o_in_ready = (mem_cnt!=DEPTH) && !rd_go.
  - push = i_in_valid && o_in_ready.
  - o_in_ready does not depend on i_in_valid.
- Memory drive:
  - rd_go: cen=1, wen=0, oen=1, addr=rd_ptr.
  - push: cen=1, wen=1, oen=0, addr=wr_ptr, data=i_in_data.
  - Otherwise: cen=0, wen=0, oen=0, addr=0, data=0.
- Updates at each edge:
  - push: wr_ptr+1, mem_cnt+1.
  - rd_go: rd_ptr+1, mem_cnt-1, rd_inflight=1.
  - Otherwise rd_inflight=0.
  - If rd_inflight: o_out_data=i_mem_data, out_valid=1.
  - Else if o_out_valid && i_out_ready: out_valid=0.
- Latency:
  - A push accepted at edge N into an empty FIFO reaches o_out_valid=1 after edge N+2.
  - Sustained pop throughput is one entry per 2 cycles.
- Capacity and count:
  - At most one of rd_inflight and out_valid is set at any time.
  - Maximum held entries is DEPTH+1.
  - o_count = mem_cnt + rd_inflight + out_valid.
- Full: mem_cnt==DEPTH forces o_in_ready=0, even if the head is popped in the same cycle.
- Empty: o_out_valid=0 and no read is issued; an i_out_ready pulse while empty is ignored.
- Wrap-around: wr_ptr and rd_ptr go DEPTH-1 -> 0 with no gap.
- Simultaneous push and rd_go: push is refused (o_in_ready=0) and the producer holds.

Decomposition:
- Shared package holds:
  - FIFO_DEPTH = 2**BW_ADDR.
  - Memory-command encodings: IDLE, WR, RD, each as a {cen,wen,oen} triple.
- No sub-module. spsram is instantiated by the parent or the bench, not inside this block.

Test Plan:
- Reset: assert i_rst 2 cycles -> o_out_valid=0, o_out_data=0, o_count=0, o_in_ready=0 during reset and 1 after, all mem strobes 0.
- Basic: push 0xA5, 0x5A, 0x33 with i_out_ready=1 -> first o_out_valid exactly 2 edges after the first push; pops appear in order 0xA5, 0x5A, 0x33; o_count returns to 0.
- Full: i_out_ready=0, push 0..40 continuously -> exactly 33 accepted; o_count=33; o_in_ready=0 with mem_cnt=32; o_out_data=0; then drain -> values 0..32 in order.
- Wrap: push/pop 80 entries interleaved -> pointers wrap twice; output sequence is identical to input, with no loss or duplication.
- Priority: i_in_valid held 1 while the head is being consumed -> on every rd_go cycle o_in_ready=0 and the mem strobes show RD; no write collides with a read.
- Mid-op reset: assert i_rst on the cycle after a read issue (rd_inflight=1) -> after reset o_out_valid=0 and o_count=0; the in-flight data never appears on o_out_data.
